// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. It processes DIGIT bits per clock, LSB chunk first,
// and keeps a one-bit ripple carry between chunks. Both sides use valid/ready handshakes.
module serial_adder #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NSTEP  = WIDTH / DIGIT;
   localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_sum;
   logic [STEP_W-1:0]   r_step;
   logic                r_carry;
   logic                r_cout;
   logic                r_ovf;
   logic [DIGIT:0]      w_chunk;
   logic                w_msb_cin;
   logic                w_accept;
   logic                w_last;
   logic [WIDTH-1:0]    w_sum_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_accept = in_ready & in_valid;
   assign w_last   = (r_step == STEP_W'(NSTEP - 1));

   // The operands shift right each step, so the current chunk is always in the low DIGIT bits.
   assign w_chunk   = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
   assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_chunk[DIGIT-1];

   for (genvar gi = 0; gi < NSTEP; gi++) begin : g_sum_chunk
      assign w_sum_next[gi*DIGIT +: DIGIT] = (r_step == STEP_W'(gi)) ? w_chunk[DIGIT-1:0]
                                                                     : r_sum[gi*DIGIT +: DIGIT];
   end

   // In subtract mode, B is stored inverted and the carry-in becomes NOT borrow-in,
   // which makes cout come out as NOT borrow-out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_step  <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b ^ {WIDTH{sub}};
         r_carry <= sub ? ~cin : cin;
         r_sum   <= '0;
         r_step  <= '0;
      end else if (r_state == S_RUN) begin
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_sum   <= w_sum_next;
         r_carry <= w_chunk[DIGIT];
         r_step  <= r_step + 1'b1;
         if (w_last) begin
            r_cout <= w_chunk[DIGIT];
            r_ovf  <= w_msb_cin ^ w_chunk[DIGIT];
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder. It runs directed vectors on an 8-bit, 2-bit-digit unit
// and random sweeps on 8-bit units with 8-bit and 1-bit digits.
module tb_serial_adder;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         acc;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       c;
      logic       o;
   } vec_t;

   localparam int NSTEP = 4;

   logic       clk;
   logic       rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
   logic [7:0] a, b, sum;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   exp_t       exp_q[$];
   logic       prev_ov = 1'b0;
   bit         sweep_done [2];
   vec_t       vecs [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_msg(input string name);
      checks++;
      errors++;
      $display("FAIL %s: actual=event missing required=event seen", name);
   endtask

   function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic mcin, input logic msub);
      exp_t       r;
      logic [7:0] bb;
      logic [8:0] t;
      bb     = msub ? ~mb : mb;
      t      = {1'b0, ma} + {1'b0, bb} + {8'd0, msub ? ~mcin : mcin};
      r.sum  = t[7:0];
      r.cout = t[8];
      r.ovf  = (ma[7] == bb[7]) && (t[7] != ma[7]);
      r.acc  = 0;
      return r;
   endfunction

   task automatic issue(input vec_t v);
      int   t;
      exp_t e;
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 64) begin @(negedge clk); t++; end
      if (t >= 64) fail_msg("accept_timeout");
      e.sum = v.s; e.cout = v.c; e.ovf = v.o; e.acc = cyc + 1;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 64) begin @(negedge clk); t++; end
      if (t >= 64) fail_msg("drain_timeout");
   endtask

   // Main monitor: whenever a result is presented, it is compared against the queue head,
   // which also verifies that the result stays stable while out_ready is held low.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0) fail_msg("unexpected_out_valid");
            else begin
               if (!prev_ov) check("latency", cyc - exp_q[0].acc, NSTEP);
               check("sum", 32'(sum), 32'(exp_q[0].sum));
               check("cout", 32'(cout), 32'(exp_q[0].cout));
               check("ovf", 32'(ovf), 32'(exp_q[0].ovf));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         prev_ov = out_valid;
      end else prev_ov = 1'b0;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
      localparam int SD = (gi == 0) ? 8 : 1;
      localparam int SN = 8 / SD;
      logic       s_rst_n, s_in_valid, s_in_ready, s_cin, s_sub;
      logic       s_out_valid, s_out_ready, s_cout, s_ovf, s_busy;
      logic [7:0] s_a, s_b, s_sum;
      exp_t       s_q[$];
      logic       s_prev_ov = 1'b0;

      serial_adder #(.WIDTH(8), .DIGIT(SD)) u_dut (
         .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
         .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
         .out_valid(s_out_valid), .out_ready(s_out_ready),
         .sum(s_sum), .cout(s_cout), .ovf(s_ovf), .busy(s_busy)
      );

      initial begin
         exp_t e;
         int   t;
         s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
         s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
         repeat (2) @(negedge clk);
         s_rst_n = 1'b1;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            s_a = 8'($urandom); s_b = 8'($urandom);
            s_cin = 1'($urandom); s_sub = 1'($urandom); s_in_valid = 1'b1;
            t = 0;
            while (!s_in_ready && t < 64) begin @(negedge clk); t++; end
            if (t >= 64) fail_msg("sweep_accept_timeout");
            e = model(s_a, s_b, s_cin, s_sub);
            e.acc = cyc + 1;
            s_q.push_back(e);
            @(posedge clk);
         end
         @(negedge clk);
         s_in_valid = 1'b0;
         t = 0;
         while (s_q.size() != 0 && t < 64) begin @(negedge clk); t++; end
         if (t >= 64) fail_msg("sweep_drain_timeout");
         sweep_done[gi] = 1'b1;
      end

      always @(negedge clk) begin
         #1;
         if (s_rst_n) begin
            if (s_out_valid) begin
               if (s_q.size() == 0) fail_msg("sweep_unexpected_out_valid");
               else begin
                  if (!s_prev_ov) check("sweep_latency", cyc - s_q[0].acc, SN);
                  check("sweep_sum", 32'(s_sum), 32'(s_q[0].sum));
                  check("sweep_cout", 32'(s_cout), 32'(s_q[0].cout));
                  check("sweep_ovf", 32'(s_ovf), 32'(s_q[0].ovf));
                  if (s_out_ready) void'(s_q.pop_front());
               end
            end
            s_prev_ov = s_out_valid;
         end else s_prev_ov = 1'b0;
      end
   end

   initial begin
      int   t;
      vec_t v;
      vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[4] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[8] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
      vecs[9] = '{8'hA5, 8'h5A, 1'b0, 1'b1, 8'h4B, 1'b1, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_cout", 32'(cout), 0);
      check("rst_ovf", 32'(ovf), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i]);
         wait_drain();
         @(negedge clk);
         check("idle_hold_sum", 32'(sum), 32'(vecs[i].s));
         check("idle_hold_cout", 32'(cout), 32'(vecs[i].c));
         check("idle_in_ready", 32'(in_ready), 1);
      end

      // Backpressure: the consumer stalls, and stray in_valid pulses must not start a new operation.
      out_ready = 1'b0;
      v = '{8'h6C, 8'h4F, 1'b0, 1'b0, 8'hBB, 1'b0, 1'b1};
      issue(v);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; a = 8'h11; b = 8'h22;
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_busy", 32'(busy), 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      repeat (3) begin
         @(negedge clk);
         check("bp_after_in_ready", 32'(in_ready), 1);
         check("bp_after_busy", 32'(busy), 0);
         check("bp_after_out_valid", 32'(out_valid), 0);
      end

      // Reset in RUN step 2 discards the operation.
      v = '{8'h33, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0};
      issue(v);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 1);
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_sum", 32'(sum), 0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      v = '{8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
      issue(v);
      wait_drain();

      t = 0;
      while (!(sweep_done[0] && sweep_done[1]) && t < 30000) begin @(negedge clk); t++; end
      if (t >= 30000) fail_msg("sweep_timeout");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
